calc_sequencer: RTL and testbench

- Host-side driver for the calculator core (FSM plus Datapath behind the `next`/`MS`/`Din`/`Done` interface).
- Accepts whole operations (opcode, operand A, operand B) on a valid/ready command port.
- Replays each operation to the core as a timed sequence of `next` pulses, waits for the core's done, and captures the ALU result.
- Returns the result on a valid/ready result port. It sits between the test/host logic and the calculator core.

---
 rtl/calc_pkg.sv | 34 +++
 rtl/calc_result_reg.sv | 38 +++
 rtl/calc_sequencer.sv | 122 ++++++++++++
 tb/tb_calc_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator-core host sequencer.
// The opcode constants mirror the calculator core's mode-select encoding.
package calc_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int MS_W_DEF   = 3;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_A,
    GAP1,
    LOAD_B,
    GAP2,
    EXEC,
    WAIT_DONE,
    ACK,
    ACK_WAIT
  } state_t;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_SHL  = 3'b111;

  // States in which the core sees a `next` step pulse.
  function automatic logic is_pulse_state(input state_t s);
    return (s == LOAD_A) || (s == LOAD_B) || (s == EXEC) || (s == ACK);
  endfunction

endpackage

// File: rtl/calc_result_reg.sv
// Single-entry valid/ready holding register for one sequencer result.
// A load is only ever requested while the slot is empty.
module calc_result_reg
  import calc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int MS_W   = MS_W_DEF
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [MS_W-1:0]   load_ms,
  input  logic              load_err,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [MS_W-1:0]   ms,
  output logic              err
);

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      valid <= 1'b0;
      data  <= '0;
      ms    <= '0;
      err   <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      ms    <= load_ms;
      err   <= load_err;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Host-side driver for the calculator core: replays a whole operation as
// timed `next` pulses, waits for done, and returns the ALU result.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int          DATA_W  = DATA_W_DEF,
  parameter int          MS_W    = MS_W_DEF,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [MS_W-1:0]   cmd_ms,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [MS_W-1:0]   res_ms,
  output logic              res_err,
  output logic              next_out,
  output logic [MS_W-1:0]   ms_out,
  output logic [DATA_W-1:0] din_out,
  input  logic              done_in,
  input  logic [DATA_W-1:0] alu_in,
  output logic              busy
);

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t            state, state_n;
  logic [7:0]        cnt, cnt_n, cnt_inc;
  logic [DATA_W-1:0] b_q;
  logic              accept;
  logic              cap, cap_err;
  logic [DATA_W-1:0] cap_data;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = (state == IDLE) && cmd_valid;
  assign cnt_inc   = (cnt == TO) ? cnt : cnt + 8'd1;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    cap      = 1'b0;
    cap_err  = 1'b0;
    cap_data = '0;
    case (state)
      IDLE:   if (accept) state_n = LOAD_A;
      LOAD_A: state_n = GAP1;
      GAP1:   state_n = LOAD_B;
      LOAD_B: state_n = GAP2;
      GAP2:   state_n = EXEC;
      EXEC: begin
        cnt_n   = '0;
        state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A full result slot stalls both a real answer and a pending timeout.
        if (done_in) begin
          if (!res_valid) begin
            cap      = 1'b1;
            cap_data = alu_in;
            state_n  = ACK;
          end
        end else begin
          cnt_n = cnt_inc;
          if ((cnt_inc == TO) && !res_valid) begin
            cap     = 1'b1;
            cap_err = 1'b1;
            state_n = IDLE;
          end
        end
      end
      ACK:      state_n = ACK_WAIT;
      ACK_WAIT: if (!done_in) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Core-facing outputs are registered from the next state.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state    <= IDLE;
      cnt      <= '0;
      b_q      <= '0;
      next_out <= 1'b0;
      ms_out   <= '0;
      din_out  <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      next_out <= is_pulse_state(state_n);
      if (accept) b_q <= cmd_b;
      if (state_n == IDLE) ms_out <= '0;
      else if (accept)     ms_out <= cmd_ms;
      if (state_n == LOAD_A)      din_out <= cmd_a;
      else if (state_n == LOAD_B) din_out <= b_q;
      else                        din_out <= '0;
    end
  end

  calc_result_reg #(
    .DATA_W (DATA_W),
    .MS_W   (MS_W)
  ) u_result (
    .clk       (clk),
    .clear     (clear),
    .load      (cap),
    .load_data (cap_data),
    .load_ms   (ms_out),
    .load_err  (cap_err),
    .ready     (res_ready),
    .valid     (res_valid),
    .data      (res_data),
    .ms        (res_ms),
    .err       (res_err)
  );

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer; the core is played by hand-timed
// done_in/alu_in stimulus with hand-computed expected results.
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        clear;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_ms;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [2:0]  res_ms;
  logic        res_err;
  logic        next_out;
  logic [2:0]  ms_out;
  logic [15:0] din_out;
  logic        done_in;
  logic [15:0] alu_in;
  logic        busy;

  int errors = 0;
  int checks = 0;

  calc_sequencer #(
    .DATA_W  (16),
    .MS_W    (3),
    .TIMEOUT (15)
  ) dut (
    .clk       (clk),
    .clear     (clear),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ms    (cmd_ms),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_ms    (res_ms),
    .res_err   (res_err),
    .next_out  (next_out),
    .ms_out    (ms_out),
    .din_out   (din_out),
    .done_in   (done_in),
    .alu_in    (alu_in),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer a command in the current (IDLE) cycle T; returns in cycle T+1.
  task automatic send_cmd(input logic [2:0] ms, input logic [15:0] a, input logic [15:0] b);
    cmd_ms    = ms;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic pop_result;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset;
    clear     = 1'b0;
    cmd_valid = 1'b0;
    cmd_ms    = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    res_ready = 1'b0;
    done_in   = 1'b0;
    alu_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
    checks++; if (next_out !== 1'b0) begin errors++; $display("[TB] FAIL rst_next: got %b want 0", next_out); end
    checks++; if (ms_out !== 3'b000) begin errors++; $display("[TB] FAIL rst_ms_out: got %b want 000", ms_out); end
    checks++; if (din_out !== 16'h0000) begin errors++; $display("[TB] FAIL rst_din: got %h want 0000", din_out); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_res_valid: got %b want 0", res_valid); end
    checks++; if (res_data !== 16'h0000) begin errors++; $display("[TB] FAIL rst_res_data: got %h want 0000", res_data); end
    checks++; if (res_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_res_err: got %b want 0", res_err); end
    clear = 1'b1;
    tick();
  endtask

  task automatic test_basic_op;
    logic [9:0] pulses;
    pulses = '0;
    send_cmd(3'b001, 16'h0005, 16'h0003);
    for (int c = 1; c <= 10; c++) begin
      pulses[c-1] = next_out;
      if (c == 1) begin
        checks++; if (din_out !== 16'h0005) begin errors++; $display("[TB] FAIL t1_din_a: got %h want 0005", din_out); end
        checks++; if (ms_out !== 3'b001) begin errors++; $display("[TB] FAIL t1_ms_out: got %b want 001", ms_out); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL t1_cmd_ready_busy: got %b want 0", cmd_ready); end
      end
      if (c == 3) begin
        checks++; if (din_out !== 16'h0003) begin errors++; $display("[TB] FAIL t1_din_b: got %h want 0003", din_out); end
      end
      if (c == 5) begin
        checks++; if (din_out !== 16'h0000) begin errors++; $display("[TB] FAIL t1_din_exec: got %h want 0000", din_out); end
      end
      if (c == 8) begin
        checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL t1_res_early: got %b want 0", res_valid); end
        done_in = 1'b1;
        alu_in  = 16'h0008;
      end
      if (c == 9) begin
        checks++; if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL t1_res_valid: got %b want 1", res_valid); end
        checks++; if (res_data !== 16'h0008) begin errors++; $display("[TB] FAIL t1_res_data: got %h want 0008", res_data); end
        checks++; if (res_ms !== 3'b001) begin errors++; $display("[TB] FAIL t1_res_ms: got %b want 001", res_ms); end
        checks++; if (res_err !== 1'b0) begin errors++; $display("[TB] FAIL t1_res_err: got %b want 0", res_err); end
      end
      if (c == 10) done_in = 1'b0;
      tick();
    end
    checks++; if (pulses !== 10'b01_0001_0101) begin errors++; $display("[TB] FAIL t1_next_pattern: got %b want 0100010101", pulses); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL t1_busy_end: got %b want 0", busy); end
    pop_result();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL t1_pop: got %b want 0", res_valid); end
  endtask

  task automatic test_timeout;
    logic ack_seen;
    ack_seen = 1'b0;
    send_cmd(3'b011, 16'h1234, 16'h5678);
    for (int c = 1; c <= 20; c++) begin
      if (c >= 6 && next_out) ack_seen = 1'b1;
      if (c == 20) begin
        checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL t2_early_timeout: got %b want 0", res_valid); end
      end
      tick();
    end
    if (next_out) ack_seen = 1'b1;
    checks++; if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL t2_res_valid: got %b want 1", res_valid); end
    checks++; if (res_err !== 1'b1) begin errors++; $display("[TB] FAIL t2_res_err: got %b want 1", res_err); end
    checks++; if (res_data !== 16'h0000) begin errors++; $display("[TB] FAIL t2_res_data: got %h want 0000", res_data); end
    checks++; if (res_ms !== 3'b011) begin errors++; $display("[TB] FAIL t2_res_ms: got %b want 011", res_ms); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL t2_busy: got %b want 0", busy); end
    checks++; if (ack_seen !== 1'b0) begin errors++; $display("[TB] FAIL t2_no_ack: got %b want 0", ack_seen); end
    pop_result();
  endtask

  task automatic test_result_stall;
    send_cmd(3'b010, 16'd10, 16'd4);
    repeat (5) tick();
    done_in = 1'b1;
    alu_in  = 16'h0006;
    tick();
    checks++; if (res_data !== 16'h0006) begin errors++; $display("[TB] FAIL t3_first_data: got %h want 0006", res_data); end
    tick();
    done_in = 1'b0;
    tick();
    send_cmd(3'b101, 16'h00F0, 16'h0FF0);
    repeat (5) tick();
    done_in = 1'b1;
    alu_in  = 16'h0F00;
    repeat (3) tick();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL t3_held_valid: got %b want 1", res_valid); end
    checks++; if (res_data !== 16'h0006) begin errors++; $display("[TB] FAIL t3_held_data: got %h want 0006", res_data); end
    checks++; if (res_ms !== 3'b010) begin errors++; $display("[TB] FAIL t3_held_ms: got %b want 010", res_ms); end
    checks++; if (next_out !== 1'b0) begin errors++; $display("[TB] FAIL t3_stall_no_ack: got %b want 0", next_out); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL t3_stall_busy: got %b want 1", busy); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL t3_popped: got %b want 0", res_valid); end
    tick();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL t3_second_valid: got %b want 1", res_valid); end
    checks++; if (res_data !== 16'h0F00) begin errors++; $display("[TB] FAIL t3_second_data: got %h want 0f00", res_data); end
    checks++; if (res_ms !== 3'b101) begin errors++; $display("[TB] FAIL t3_second_ms: got %b want 101", res_ms); end
    checks++; if (next_out !== 1'b1) begin errors++; $display("[TB] FAIL t3_second_ack: got %b want 1", next_out); end
    tick();
    done_in = 1'b0;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL t3_idle: got %b want 1", cmd_ready); end
    pop_result();
  endtask

  task automatic test_clear_midop;
    send_cmd(3'b110, 16'h0001, 16'h0002);
    repeat (6) tick();
    checks++; if (ms_out !== 3'b110) begin errors++; $display("[TB] FAIL t4_ms_before: got %b want 110", ms_out); end
    #2 clear = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL t4_cmd_ready: got %b want 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL t4_busy: got %b want 0", busy); end
    checks++; if (ms_out !== 3'b000) begin errors++; $display("[TB] FAIL t4_ms_out: got %b want 000", ms_out); end
    checks++; if (res_data !== 16'h0000) begin errors++; $display("[TB] FAIL t4_res_data: got %h want 0000", res_data); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL t4_res_valid: got %b want 0", res_valid); end
    tick();
    clear = 1'b1;
    tick();
    send_cmd(3'b011, 16'h00FF, 16'h0F0F);
    checks++; if (din_out !== 16'h00FF) begin errors++; $display("[TB] FAIL t4_din_a: got %h want 00ff", din_out); end
    checks++; if (next_out !== 1'b1) begin errors++; $display("[TB] FAIL t4_next: got %b want 1", next_out); end
    repeat (5) tick();
    done_in = 1'b1;
    alu_in  = 16'h000F;
    tick();
    checks++; if (res_data !== 16'h000F) begin errors++; $display("[TB] FAIL t4_res_data_after: got %h want 000f", res_data); end
    checks++; if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL t4_res_valid_after: got %b want 1", res_valid); end
    tick();
    done_in = 1'b0;
    tick();
    pop_result();
  endtask

  task automatic test_back_to_back;
    logic [2:0]  op_ms  [4];
    logic [15:0] op_a   [4];
    logic [15:0] op_b   [4];
    logic [15:0] op_res [4];
    logic        prev_next;
    int          bad_ready;
    int          double_pulse;
    op_ms[0] = 3'b001; op_a[0] = 16'h0001; op_b[0] = 16'h0001; op_res[0] = 16'h0002;
    op_ms[1] = 3'b010; op_a[1] = 16'h0009; op_b[1] = 16'h0004; op_res[1] = 16'h0005;
    op_ms[2] = 3'b100; op_a[2] = 16'h00F0; op_b[2] = 16'h000F; op_res[2] = 16'h00FF;
    op_ms[3] = 3'b111; op_a[3] = 16'h0001; op_b[3] = 16'h0004; op_res[3] = 16'h0010;
    prev_next    = 1'b0;
    bad_ready    = 0;
    double_pulse = 0;
    cmd_ms    = op_ms[0];
    cmd_a     = op_a[0];
    cmd_b     = op_b[0];
    cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL t5_ready_op%0d: got %b want 1", i, cmd_ready); end
      tick();
      if (i < 3) begin
        cmd_ms = op_ms[i+1];
        cmd_a  = op_a[i+1];
        cmd_b  = op_b[i+1];
      end else begin
        cmd_valid = 1'b0;
      end
      for (int c = 1; c <= 8; c++) begin
        if (next_out && prev_next) double_pulse++;
        prev_next = next_out;
        if (cmd_ready !== 1'b0) bad_ready++;
        if (c == 1) begin
          checks++; if (din_out !== op_a[i]) begin errors++; $display("[TB] FAIL t5_din_op%0d: got %h want %h", i, din_out, op_a[i]); end
          checks++; if (ms_out !== op_ms[i]) begin errors++; $display("[TB] FAIL t5_ms_op%0d: got %b want %b", i, ms_out, op_ms[i]); end
        end
        if (c == 6) begin
          done_in = 1'b1;
          alu_in  = op_res[i];
        end
        if (c == 7) begin
          checks++; if (res_data !== op_res[i]) begin errors++; $display("[TB] FAIL t5_data_op%0d: got %h want %h", i, res_data, op_res[i]); end
          checks++; if (res_ms !== op_ms[i]) begin errors++; $display("[TB] FAIL t5_res_ms_op%0d: got %b want %b", i, res_ms, op_ms[i]); end
          res_ready = 1'b1;
        end
        if (c == 8) begin
          done_in   = 1'b0;
          res_ready = 1'b0;
        end
        tick();
      end
    end
    checks++; if (bad_ready !== 0) begin errors++; $display("[TB] FAIL t5_ready_not_idle: got %0d cycles want 0", bad_ready); end
    checks++; if (double_pulse !== 0) begin errors++; $display("[TB] FAIL t5_double_pulse: got %0d want 0", double_pulse); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL t5_final_empty: got %b want 0", res_valid); end
  endtask

  task automatic test_late_done_drop;
    int stuck;
    stuck = 0;
    send_cmd(3'b100, 16'h00F0, 16'h000F);
    repeat (5) tick();
    done_in = 1'b1;
    alu_in  = 16'h00FF;
    tick();
    checks++; if (next_out !== 1'b1) begin errors++; $display("[TB] FAIL t6_ack: got %b want 1", next_out); end
    for (int c = 8; c <= 10; c++) begin
      tick();
      if (cmd_ready !== 1'b0 || next_out !== 1'b0 || busy !== 1'b1) stuck++;
    end
    checks++; if (stuck !== 0) begin errors++; $display("[TB] FAIL t6_ack_wait_hold: got %0d bad cycles want 0", stuck); end
    done_in = 1'b0;
    tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL t6_idle_ready: got %b want 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL t6_idle_busy: got %b want 0", busy); end
    checks++; if (res_data !== 16'h00FF) begin errors++; $display("[TB] FAIL t6_res_data: got %h want 00ff", res_data); end
    pop_result();
  endtask

  initial begin
    $display("[TB] calc_sequencer directed bench start");
    test_reset();
    test_basic_op();
    test_timeout();
    test_result_stall();
    test_clear_midop();
    test_back_to_back();
    test_late_done_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
